// File: rtl/contador_modular_pkg.sv
// Shared definitions for the modular counter: operation encodings seen on operacao.
package contador_modular_pkg;

   typedef enum logic [1:0] {
      OP_UP   = 2'b00,
      OP_DOWN = 2'b01,
      OP_LOAD = 2'b10,
      OP_HOLD = 2'b11
   } op_t;

endpackage

// File: rtl/contador_modular_prescaler.sv
// Enable divider: tick is high on every PRESCALE-th enabled edge; sync_clr restarts the phase.
module contador_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic clr_n,
   input  logic en,
   input  logic sync_clr,
   output logic tick
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] fase;

   if (PRESCALE < 1) begin : g_bad_prescale
      $error("contador_prescaler: PRESCALE must be >= 1");
   end

   // With PRESCALE=1 the phase register never leaves 0, so tick stays high.
   assign tick = (fase == LAST);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         fase <= '0;
      end else if (en) begin
         if (sync_clr || tick) fase <= '0;
         else                  fase <= fase + 1'b1;
      end
   end

endmodule

// File: rtl/contador_modular.sv
// Modulo-N up/down/load counter with optional saturation, prescaled counting and event pulses.
module contador_modular
   import contador_modular_pkg::*;
#(
   parameter int WIDTH    = 6,
   parameter int MODULO   = 60,
   parameter int SATURATE = 0,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             en,
   input  logic [1:0]       operacao,
   input  logic [WIDTH-1:0] valor,
   output logic [WIDTH-1:0] cont,
   output logic             tc,
   output logic             ovf,
   output logic             udf,
   output logic             load_err
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULO - 1);

   if (MODULO < 2 || MODULO > 2**WIDTH) begin : g_bad_modulo
      $error("contador_modular: MODULO must lie in 2..2**WIDTH");
   end
   if (SATURATE != 0 && SATURATE != 1) begin : g_bad_saturate
      $error("contador_modular: SATURATE must be 0 or 1");
   end

   op_t  op;
   logic tick;

   assign op = op_t'(operacao);

   // Hold freezes the prescaler phase as well as the count; a load restarts it.
   contador_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk      (clk),
      .clr_n    (clr_n),
      .en       (en && (op != OP_HOLD)),
      .sync_clr (op == OP_LOAD),
      .tick     (tick)
   );

   assign tc = ((op == OP_UP) && (cont == MAXV)) || ((op == OP_DOWN) && (cont == '0));

   // Range checks come before the arithmetic so cont never leaves 0..MODULO-1.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cont     <= '0;
         ovf      <= 1'b0;
         udf      <= 1'b0;
         load_err <= 1'b0;
      end else begin
         ovf      <= 1'b0;
         udf      <= 1'b0;
         load_err <= 1'b0;
         if (en) begin
            case (op)
               OP_LOAD: begin
                  if (valor > MAXV) begin
                     cont     <= MAXV;
                     load_err <= 1'b1;
                  end else begin
                     cont <= valor;
                  end
               end
               OP_UP: begin
                  if (tick) begin
                     if (cont == MAXV) begin
                        ovf <= 1'b1;
                        if (SATURATE == 0) cont <= '0;
                     end else begin
                        cont <= cont + 1'b1;
                     end
                  end
               end
               OP_DOWN: begin
                  if (tick) begin
                     if (cont == '0) begin
                        udf <= 1'b1;
                        if (SATURATE == 0) cont <= MAXV;
                     end else begin
                        cont <= cont - 1'b1;
                     end
                  end
               end
               OP_HOLD: ;
            endcase
         end
      end
   end

endmodule

// File: doc/contador_modular.md
CONTADOR_MODULAR -- requirements
Module: contador_modular

Interface
REQ-001 Parameter WIDTH, default 6: counter width in bits.
REQ-002 Parameter MODULO, default 60: count range 0..MODULO-1; legal range 2..2**WIDTH.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at the range ends, 1 = saturate at the range ends.
REQ-004 Parameter PRESCALE, default 1: count operations execute once every PRESCALE enabled cycles; legal range >= 1.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 clr_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  enable; when 0, all state holds.
REQ-008 operacao  input  2  00 up, 01 down, 10 load, 11 hold.
REQ-009 valor  input  WIDTH  load value.
REQ-010 cont  output  WIDTH  registered count.
REQ-011 tc  output  1  combinational terminal-count indication.
REQ-012 ovf  output  1  registered one-cycle pulse: up-count at MODULO-1.
REQ-013 udf  output  1  registered one-cycle pulse: down-count at 0.
REQ-014 load_err  output  1  registered one-cycle pulse: out-of-range load.

Function
REQ-015 A prescaler counter (0..PRESCALE-1) shall advance on each clk edge with en=1.
REQ-016 The prescaler shall assert tick when its value equals PRESCALE-1, then return to 0 on the next enabled edge.
REQ-017 With PRESCALE=1, tick shall be constantly 1.
REQ-018 Up (00) or down (01) shall change cont only on an edge with en=1 and tick=1.
REQ-019 Up: cont<MODULO-1 -> cont+1; cont=MODULO-1 -> cont=0 (SATURATE=0) or cont unchanged (SATURATE=1), ovf=1 next cycle in both modes.
REQ-020 Down: cont>0 -> cont-1; cont=0 -> cont=MODULO-1 (SATURATE=0) or cont unchanged (SATURATE=1), udf=1 next cycle in both modes.
REQ-021 Load (10) shall execute on any edge with en=1, independent of tick, and shall clear the prescaler to 0.
REQ-022 Load with valor<=MODULO-1 shall set cont=valor.
REQ-023 Load with valor>MODULO-1 shall set cont=MODULO-1 and pulse load_err for one cycle.
REQ-024 Hold (11), or en=0, shall keep cont and the prescaler unchanged.
REQ-025 ovf, udf and load_err shall be 0 on every edge other than the triggering one; at most one of them may be high in any cycle.
REQ-026 tc shall be 1 iff (operacao=00 and cont=MODULO-1) or (operacao=01 and cont=0), irrespective of en and tick.
REQ-027 All arithmetic shall be WIDTH bits, with range checks done before the increment or decrement, so cont never leaves 0..MODULO-1.
REQ-028 A change of operacao between ticks shall take effect at the next tick; the prescaler shall not be reset.

Reset
REQ-029 clr_n=0 shall immediately and asynchronously set cont=0, prescaler=0, ovf=udf=load_err=0.
REQ-030 Reset asserted mid-prescale or mid-pulse shall abort the operation; no pulse shall appear after release.
REQ-031 The first enabled edge after clr_n rises shall be prescaler count 0.

Structure
REQ-032 A shared package shall hold the operacao encodings OP_UP, OP_DOWN, OP_LOAD and OP_HOLD.
REQ-033 The prescaler shall be a sub-module, contador_prescaler (parameter PRESCALE; ports clk, clr_n, en, sync_clr, tick).
REQ-034 Illegal MODULO or PRESCALE values shall be rejected at elaboration.

Verification (WIDTH=6, MODULO=60 unless stated)
REQ-035 PRESCALE=1, SATURATE=0: up from 58 -> 59, then 0 with ovf=1 for one cycle; tc=1 while cont=59 and operacao=00.
REQ-036 SATURATE=1: down from 1 -> 0, then 0 with udf=1; repeated down holds 0 and pulses udf on each edge.
REQ-037 Load valor=45 -> cont=45, load_err=0; load valor=63 -> cont=59, load_err=1 for one cycle.
REQ-038 PRESCALE=4, en=1, up from 0: cont=1 after 4 edges, 2 after 8; en=0 for 3 cycles in between delays the count by 3 cycles.
REQ-039 Assert clr_n=0 between edges at cont=30: cont=0 with no clock edge; after release, the first up tick arrives at the PRESCALE-th edge.
REQ-040 Hold (11) for 10 edges at cont=17 -> cont=17 and all flags 0.
